// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier: state encoding,
// state type and the iteration-counter sizing helper.
package mul_pkg;

  // Raw state encodings, kept as plain constants for older code that
  // compares against bit patterns directly.
  localparam logic [1:0] ENC_IDLE = 2'b00;
  localparam logic [1:0] ENC_CALC = 2'b01;
  localparam logic [1:0] ENC_FIX  = 2'b10;
  localparam logic [1:0] ENC_DONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_CALC = ENC_CALC,
    ST_FIX  = ENC_FIX,
    ST_DONE = ENC_DONE
  } state_t;

  // Counter must be able to hold the value WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/add_n.sv
// Combinational WIDTH-bit adder with carry-out; used for hi + |A| in
// each shift-add iteration.
module add_n #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier with optional signed mode and
// valid/ready handshakes. Magnitudes are multiplied unsigned over WIDTH
// cycles, then the sign is applied in a single FIX cycle so latency does
// not depend on the mode. WIDTH must be at least 2.
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t              state_reg, state_next;
  logic [WIDTH-1:0]    a_reg, a_next;
  logic                neg_reg, neg_next;
  logic [2*WIDTH:0]    acc_reg, acc_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [2*WIDTH-1:0]  product_reg, product_next;

  // Operand conditioning at accept: sign detection and magnitudes.
  // The magnitude of the most-negative value wraps to itself, which is
  // exactly the correct unsigned magnitude 2^(WIDTH-1).
  logic             signed_mode;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign signed_mode = SIGNED_EN && is_signed;
  assign a_neg = signed_mode && multiplicand[WIDTH-1];
  assign b_neg = signed_mode && multiplier[WIDTH-1];
  assign a_mag = a_neg ? (~multiplicand + 1'b1) : multiplicand;
  assign b_mag = b_neg ? (~multiplier + 1'b1) : multiplier;

  // One shift-add step on {carry, hi, lo}.
  logic [WIDTH-1:0] sum;
  logic             sum_cout;
  logic [2*WIDTH:0] acc_step;

  add_n #(.WIDTH(WIDTH)) u_add (
    .a    (acc_reg[2*WIDTH-1:WIDTH]),
    .b    (a_reg),
    .sum  (sum),
    .cout (sum_cout)
  );

  assign acc_step = acc_reg[0] ? {1'b0, sum_cout, sum, acc_reg[WIDTH-1:1]}
                               : {1'b0, acc_reg[2*WIDTH:1]};

  // Two's complement of the unsigned product, applied when signs differ.
  logic [2*WIDTH-1:0] acc_negated;
  assign acc_negated = ~acc_reg[2*WIDTH-1:0] + 1'b1;

  // Next-state and datapath update selection for each FSM state.
  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    neg_next     = neg_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    product_next = product_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          a_next     = a_mag;
          neg_next   = a_neg ^ b_neg;
          acc_next   = {1'b0, {WIDTH{1'b0}}, b_mag};
          cnt_next   = '0;
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_next = acc_step;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_ITER) begin
          state_next = ST_FIX;
        end
      end
      ST_FIX: begin
        product_next = neg_reg ? acc_negated : acc_reg[2*WIDTH-1:0];
        state_next   = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      a_reg       <= '0;
      neg_reg     <= 1'b0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      neg_reg     <= neg_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      product_reg <= product_next;
    end
  end

  assign in_ready  = rst_n && (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg == ST_CALC) || (state_reg == ST_FIX);
  assign product   = product_reg;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: a 32-bit signed-capable instance, an 8-bit
// signed-capable instance and an 8-bit unsigned-only instance share clock
// and reset. Expected values are hand-computed constants.
module tb_mul_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 32-bit, SIGNED_EN=1
  logic        iv32, ir32, sg32, ov32, or32, bz32;
  logic [31:0] a32, b32;
  logic [63:0] p32;
  // 8-bit, SIGNED_EN=1
  logic        iv8s, ir8s, sg8s, ov8s, or8s, bz8s;
  logic [7:0]  a8s, b8s;
  logic [15:0] p8s;
  // 8-bit, SIGNED_EN=0
  logic        iv8u, ir8u, sg8u, ov8u, or8u, bz8u;
  logic [7:0]  a8u, b8u;
  logic [15:0] p8u;

  mul_seq #(.WIDTH(32), .SIGNED_EN(1'b1)) u_m32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
    .is_signed(sg32), .multiplicand(a32), .multiplier(b32),
    .out_valid(ov32), .out_ready(or32), .product(p32), .busy(bz32)
  );

  mul_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) u_m8s (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8s), .in_ready(ir8s),
    .is_signed(sg8s), .multiplicand(a8s), .multiplier(b8s),
    .out_valid(ov8s), .out_ready(or8s), .product(p8s), .busy(bz8s)
  );

  mul_seq #(.WIDTH(8), .SIGNED_EN(1'b0)) u_m8u (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8u), .in_ready(ir8u),
    .is_signed(sg8u), .multiplicand(a8u), .multiplier(b8u),
    .out_valid(ov8u), .out_ready(or8u), .product(p8u), .busy(bz8u)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One 32-bit operation; returns cycles from accept edge to out_valid.
  // Optionally pulses in_valid with different operands mid-CALC.
  task automatic run32(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input bit pulse, output int lat);
    @(negedge clk);
    sg32 = s; a32 = a; b32 = b; iv32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv32 = 1'b0;
    lat = 0;
    while (!ov32 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (pulse && lat == 5) begin
        iv32 = 1'b1; a32 = 32'h0000_1234; b32 = 32'h0000_5678; sg32 = 1'b0;
      end else begin
        iv32 = 1'b0;
      end
    end
    $display("txn w32 signed=%0b a=%h b=%h product=%h latency=%0d", s, a, b, p32, lat);
  endtask

  initial begin
    int lat, n, t1, t2;
    bit seen;
    logic [63:0] held;

    rst_n = 1'b0;
    iv32 = 0; sg32 = 0; a32 = 0; b32 = 0; or32 = 1;
    iv8s = 0; sg8s = 0; a8s = 0; b8s = 0; or8s = 1;
    iv8u = 0; sg8u = 0; a8u = 0; b8u = 0; or8u = 1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready_low", {63'd0, ir32}, 64'd0);
    chk("rst_product", p32, 64'd0);
    chk("rst_out_valid", {63'd0, ov32}, 64'd0);
    chk("rst_busy", {63'd0, bz32}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", {63'd0, ir32}, 64'd1);

    // Unsigned max*max, out_ready held low in DONE
    or32 = 1'b0;
    run32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    chk("umax_latency", 64'(lat), 64'd33);
    chk("umax_product", p32, 64'hFFFF_FFFE_0000_0001);
    chk("umax_busy_done", {63'd0, bz32}, 64'd0);
    repeat (5) @(negedge clk);
    chk("hold_out_valid", {63'd0, ov32}, 64'd1);
    chk("hold_product", p32, 64'hFFFF_FFFE_0000_0001);
    chk("hold_in_ready", {63'd0, ir32}, 64'd0);
    or32 = 1'b1;
    @(negedge clk);
    chk("drain_out_valid", {63'd0, ov32}, 64'd0);
    chk("drain_in_ready", {63'd0, ir32}, 64'd1);
    chk("drain_product_stable", p32, 64'hFFFF_FFFE_0000_0001);

    // Signed -3*7 with a spurious in_valid pulse during CALC
    run32(1'b1, 32'hFFFF_FFFD, 32'd7, 1'b1, lat);
    chk("s_m3x7_product", p32, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("s_m3x7_latency", 64'(lat), 64'd33);

    // Same operands, unsigned
    run32(1'b0, 32'hFFFF_FFFD, 32'd7, 1'b0, lat);
    chk("u_fffffffd_x7_product", p32, 64'h0000_0006_FFFF_FFEB);

    // 8-bit signed, back-to-back accepts with in_valid held high
    @(negedge clk);
    sg8s = 1'b1; a8s = 8'h80; b8s = 8'h80; iv8s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b8s = 8'h7F;
    n = 0;
    while (!ov8s && n < 60) begin @(posedge clk); n++; @(negedge clk); end
    t1 = n;
    chk("s8_80x80_latency", 64'(t1), 64'd9);
    chk("s8_80x80_product", {48'd0, p8s}, 64'h4000);
    $display("txn w8s a=80 b=80 product=%h latency=%0d", p8s, t1);
    while (ov8s && n < 60) begin @(posedge clk); n++; @(negedge clk); end
    while (!ov8s && n < 60) begin @(posedge clk); n++; @(negedge clk); end
    t2 = n;
    iv8s = 1'b0;
    chk("s8_b2b_second_done", 64'(t2), 64'd20);
    chk("s8_80x7f_product", {48'd0, p8s}, 64'hC080);
    $display("txn w8s a=80 b=7f product=%h done_at=%0d", p8s, t2);

    // 8-bit with signed mode disabled
    @(negedge clk);
    sg8u = 1'b1; a8u = 8'h80; b8u = 8'h02; iv8u = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8u = 1'b0;
    n = 0;
    while (!ov8u && n < 60) begin @(posedge clk); n++; @(negedge clk); end
    chk("u8_mode_ignored_product", {48'd0, p8u}, 64'h0100);
    chk("u8_latency", 64'(n), 64'd9);
    $display("txn w8u a=80 b=02 product=%h latency=%0d", p8u, n);

    // Reset asserted mid-CALC
    @(negedge clk);
    sg32 = 1'b0; a32 = 32'h0001_2345; b32 = 32'h0006_789A; iv32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv32 = 1'b0;
    repeat (9) @(negedge clk);
    held = p32;
    chk("midcalc_busy", {63'd0, bz32}, 64'd1);
    chk("midcalc_product_prev", held, 64'h0000_0006_FFFF_FFEB);
    rst_n = 1'b0;
    #1;
    chk("arst_product", p32, 64'd0);
    chk("arst_busy", {63'd0, bz32}, 64'd0);
    chk("arst_out_valid", {63'd0, ov32}, 64'd0);
    chk("arst_in_ready", {63'd0, ir32}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, ir32}, 64'd1);
    chk("post_rst_product", p32, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ov32) seen = 1'b1;
    end
    chk("post_rst_no_result", {63'd0, seen}, 64'd0);
    run32(1'b1, 32'd5, 32'd6, 1'b0, lat);
    chk("post_rst_5x6_product", p32, 64'd30);
    chk("post_rst_5x6_latency", 64'(lat), 64'd33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
